// File: rtl/adder.sv
// Registered ripple-carry adder built from gate-primitive full-adder cells.
// {cout, S} = X + Y, one-cycle latency, synchronous active-high reset.

module adder #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   c;

    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;

    assign c[0] = 1'b0;

    // One full-adder cell per bit: c[i+1] = g[i] | (p[i] & c[i]).
    for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
        and u_g  (g[i],    X[i], Y[i]);
        xor u_p  (p[i],    X[i], Y[i]);
        xor u_s  (s[i],    p[i], c[i]);
        and u_pc (pc[i],   p[i], c[i]);
        or  u_c  (c[i+1],  g[i], pc[i]);
    end

    assign sum_d = {c[WIDTH], s};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign S    = sum_q[WIDTH-1:0];
    assign cout = sum_q[WIDTH];

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: scoreboard queue of expected {cout,S},
// pushed when operands are driven and popped one cycle later.

module tb_adder;

    logic       clk;
    logic       rst;
    logic [5:0] X;
    logic [5:0] Y;
    logic [5:0] S;
    logic       cout;

    int checks;
    int failures;

    logic [6:0] sb[$];

    adder #(.WIDTH(6)) dut (
        .clk  (clk),
        .rst  (rst),
        .X    (X),
        .Y    (Y),
        .S    (S),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands at the falling edge, record the expected result, then
    // move to just after the next rising edge where the result is visible.
    task automatic step(input logic [5:0] x, input logic [5:0] y, input logic r);
        @(negedge clk);
        X   = x;
        Y   = y;
        rst = r;
        sb.push_back(r ? 7'd0 : ({1'b0, x} + {1'b0, y}));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        step(6'd63, 6'd63, 1'b1);
        exp = sb.pop_front();
        checks++;
        if ({cout, S} !== exp || exp !== 7'd0) begin
            failures++;
            $display("FAIL reset_clear got=%b req=%b", {cout, S}, 7'd0);
        end
        step(6'd63, 6'd63, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({cout, S} !== 7'd126) begin
            failures++;
            $display("FAIL reset_release got=%0d req=%0d", {cout, S}, 7'd126);
        end
        checks++;
        if ({cout, S} !== exp) begin
            failures++;
            $display("FAIL reset_release_sb got=%0d req=%0d", {cout, S}, exp);
        end
    endtask

    task automatic test_basic();
        logic [6:0] exp;
        logic [5:0] xs[4] = '{6'd0, 6'd21, 6'd63, 6'd32};
        logic [5:0] ys[4] = '{6'd0, 6'd42, 6'd1, 6'd32};
        logic [6:0] req[4] = '{7'd0, 7'd63, 7'd64, 7'd64};
        for (int k = 0; k < 4; k++) begin
            step(xs[k], ys[k], 1'b0);
            exp = sb.pop_front();
            checks++;
            if ({cout, S} !== req[k] || exp !== req[k]) begin
                failures++;
                $display("FAIL basic_%0d x=%0d y=%0d got=%0d req=%0d",
                         k, xs[k], ys[k], {cout, S}, req[k]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [6:0] exp;
        logic [11:0] v;
        int errs;
        int first_idx;
        errs      = 0;
        first_idx = -1;
        for (int i = 0; i < 4096; i++) begin
            v = i[11:0];
            step(v[11:6], v[5:0], 1'b0);
            exp = sb.pop_front();
            checks++;
            if ({cout, S} !== exp) begin
                failures++;
                errs++;
                if (first_idx < 0) first_idx = i;
                if (errs <= 4) begin
                    $display("FAIL exhaustive idx=%0d x=%0d y=%0d got=%0d req=%0d",
                             i, v[11:6], v[5:0], {cout, S}, exp);
                end
            end
        end
        $display("exhaustive: errors=%0d first_failing_index=%0d", errs, first_idx);
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        step(6'd1, 6'd1, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({cout, S} !== 7'd2 || exp !== 7'd2) begin
            failures++;
            $display("FAIL b2b_first got=%0d req=%0d", {cout, S}, 7'd2);
        end
        step(6'd63, 6'd63, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({cout, S} !== 7'd126 || exp !== 7'd126) begin
            failures++;
            $display("FAIL b2b_second got=%0d req=%0d", {cout, S}, 7'd126);
        end
    endtask

    task automatic test_glitch();
        logic [6:0] exp;
        step(6'd10, 6'd20, 1'b0);
        exp = sb.pop_front();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            X = 6'($urandom);
            Y = 6'($urandom);
            #1;
            checks++;
            if ({cout, S} !== exp) begin
                failures++;
                $display("FAIL glitch_%0d got=%0d req=%0d", k, {cout, S}, exp);
            end
        end
        sb.push_back({1'b0, X} + {1'b0, Y});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checks++;
        if ({cout, S} !== exp) begin
            failures++;
            $display("FAIL glitch_load got=%0d req=%0d", {cout, S}, exp);
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] exp;
        logic [5:0] xs[3] = '{6'd5, 6'd40, 6'd7};
        logic [5:0] ys[3] = '{6'd6, 6'd30, 6'd8};
        logic       rs[3] = '{1'b0, 1'b1, 1'b0};
        logic [6:0] req[3] = '{7'd11, 7'd0, 7'd15};
        for (int k = 0; k < 3; k++) begin
            step(xs[k], ys[k], rs[k]);
            exp = sb.pop_front();
            checks++;
            if ({cout, S} !== req[k] || exp !== req[k]) begin
                failures++;
                $display("FAIL mid_reset_%0d got=%0d req=%0d", k, {cout, S}, req[k]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        X        = '0;
        Y        = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_mid_reset();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
